// File: rtl/vjtag_dr_responder.sv
// Virtual-JTAG DR handler: shifts DR_W-bit words, commits host writes (IR=1), captures fabric reads (IR=0).
// Latency: tdo = shreg[0] combinationally; wr_valid / rd_ack assert the cycle after update-DR.
// Backpressure: wr_valid holds until wr_ready; a commit while a word is still pending is dropped and sets ovr.
module vjtag_dr_responder #(
  parameter int DR_W = 32
) (
  input  logic            tck,
  input  logic            rst,
  input  logic            tdi,
  output logic            tdo,
  input  logic            ir_in,
  output logic            ir_out,
  input  logic            virtual_state_cdr,
  input  logic            virtual_state_sdr,
  input  logic            virtual_state_e1dr,
  input  logic            virtual_state_pdr,
  input  logic            virtual_state_e2dr,
  input  logic            virtual_state_udr,
  input  logic            virtual_state_cir,
  input  logic            virtual_state_uir,
  output logic [DR_W-1:0] wr_data,
  output logic            wr_valid,
  input  logic            wr_ready,
  input  logic [DR_W-1:0] rd_data,
  output logic            rd_ack
);

  localparam int CW = $clog2(DR_W + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DR_W);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DR_W + 1);

  typedef struct packed {
    logic wr_valid;
    logic ovr;
    logic len_err;
  } status_t;

  logic [DR_W-1:0] shreg;
  logic [CW-1:0]   bit_cnt;
  logic            len_err;
  logic            ovr;
  logic            dr_hold;
  status_t         status;

  assign tdo     = shreg[0];
  assign dr_hold = virtual_state_e1dr | virtual_state_pdr | virtual_state_e2dr;
  assign status  = '{wr_valid: wr_valid, ovr: ovr, len_err: len_err};

  always_ff @(posedge tck) begin
    if (rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      wr_data  <= '0;
      wr_valid <= 1'b0;
      rd_ack   <= 1'b0;
      ir_out   <= 1'b0;
      len_err  <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      rd_ack <= 1'b0;
      // Fabric handshake runs independently of the scan; a commit below overrides the clear.
      if (wr_valid && wr_ready) wr_valid <= 1'b0;

      if (virtual_state_cdr) begin
        bit_cnt <= '0;
        shreg   <= ir_in ? {{(DR_W-3){1'b0}}, status} : rd_data;
      end else if (virtual_state_sdr) begin
        shreg <= {tdi, shreg[DR_W-1:1]};
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CW'(1);
      end else if (virtual_state_udr) begin
        if (bit_cnt != CNT_FULL) begin
          len_err <= 1'b1;
        end else if (ir_in) begin
          if (!wr_valid || wr_ready) begin
            wr_data  <= shreg;
            wr_valid <= 1'b1;
          end else begin
            ovr <= 1'b1;
          end
        end else begin
          rd_ack <= 1'b1;
        end
      end else if (virtual_state_cir) begin
        ir_out <= wr_valid;
      end else if (virtual_state_uir) begin
        len_err <= 1'b0;
        ovr     <= 1'b0;
      end else if (dr_hold) begin
        // Pause/exit states freeze the scan mid-word.
        shreg <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_vjtag_dr_responder.sv
// Bench for vjtag_dr_responder: bit-stream scoreboard model checked every cycle plus directed literal checks.
module tb_vjtag_dr_responder;
  localparam int DR_W = 32;
  localparam int P_NONE = 0, P_CDR = 1, P_SDR = 2, P_E1 = 3, P_PDR = 4,
                 P_E2 = 5, P_UDR = 6, P_CIR = 7, P_UIR = 8;

  logic tck = 1'b0;
  logic rst, tdi, tdo, ir_in, ir_out;
  logic cdr, sdr, e1dr, pdr, e2dr, udr, cir, uir;
  logic [DR_W-1:0] wr_data, rd_data;
  logic wr_valid, wr_ready, rd_ack;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 tck = ~tck;

  vjtag_dr_responder #(.DR_W(DR_W)) dut (
    .tck(tck), .rst(rst), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
    .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_e1dr(e1dr),
    .virtual_state_pdr(pdr), .virtual_state_e2dr(e2dr), .virtual_state_udr(udr),
    .virtual_state_cir(cir), .virtual_state_uir(uir),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_ack(rd_ack)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: the scan is a bit stream (captured word LSB-first, then every tdi shifted in);
  // after n shifts tdo shows stream[n] and the register holds stream[n +: DR_W].
  bit              stream[$];
  int              n_shift;
  bit              model_on = 1'b0;
  logic [DR_W-1:0] m_wr_data;
  logic            m_wr_valid, m_rd_ack, m_ir_out, m_len_err, m_ovr;
  logic            m_commit, m_hs;
  logic [DR_W-1:0] m_cap;

  always @(posedge tck) begin
    if (rst) begin
      stream.delete();
      for (int i = 0; i < DR_W; i++) stream.push_back(1'b0);
      n_shift = 0;
      m_wr_data = '0; m_wr_valid = 1'b0; m_rd_ack = 1'b0;
      m_ir_out = 1'b0; m_len_err = 1'b0; m_ovr = 1'b0;
      model_on = 1'b1;
    end else if (model_on) begin
      m_commit = 1'b0;
      m_hs = m_wr_valid && wr_ready;
      m_rd_ack = 1'b0;
      if (cdr) begin
        m_cap = ir_in ? DR_W'({m_wr_valid, m_ovr, m_len_err}) : rd_data;
        stream.delete();
        for (int i = 0; i < DR_W; i++) stream.push_back(m_cap[i]);
        n_shift = 0;
      end else if (sdr) begin
        stream.push_back(tdi);
        n_shift++;
      end else if (udr) begin
        if (n_shift != DR_W) m_len_err = 1'b1;
        else if (!ir_in) m_rd_ack = 1'b1;
        else if (!m_wr_valid || wr_ready) begin
          for (int i = 0; i < DR_W; i++) m_wr_data[i] = stream[n_shift + i];
          m_commit = 1'b1;
        end else m_ovr = 1'b1;
      end else if (cir) begin
        m_ir_out = m_wr_valid;
      end else if (uir) begin
        m_len_err = 1'b0;
        m_ovr = 1'b0;
      end
      if (m_commit) m_wr_valid = 1'b1;
      else if (m_hs) m_wr_valid = 1'b0;
    end
  end

  always @(posedge tck) begin
    #2;
    if (model_on) begin
      check("tdo",      64'(tdo),      64'(stream[n_shift]));
      check("wr_valid", 64'(wr_valid), 64'(m_wr_valid));
      check("wr_data",  64'(wr_data),  64'(m_wr_data));
      check("rd_ack",   64'(rd_ack),   64'(m_rd_ack));
      check("ir_out",   64'(ir_out),   64'(m_ir_out));
    end
  end

  task automatic clear_strobes();
    cdr = 0; sdr = 0; e1dr = 0; pdr = 0; e2dr = 0; udr = 0; cir = 0; uir = 0;
  endtask

  task automatic pulse(input int s, input logic d);
    clear_strobes();
    cdr = (s == P_CDR); sdr = (s == P_SDR); e1dr = (s == P_E1); pdr = (s == P_PDR);
    e2dr = (s == P_E2); udr = (s == P_UDR); cir = (s == P_CIR); uir = (s == P_UIR);
    tdi = d;
    @(negedge tck);
    clear_strobes();
    tdi = 1'b0;
  endtask

  // Full DR scan: capture, shift nbits of w (optional 5-cycle pause before bit pause_at), update.
  task automatic dr_scan(input logic ir, input logic [DR_W-1:0] w, input int nbits,
                         input int pause_at, output logic [DR_W-1:0] out);
    out = '0;
    ir_in = ir;
    pulse(P_CDR, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      if (i == pause_at) begin
        pulse(P_E1, 1'b0);
        for (int k = 0; k < 5; k++) pulse(P_PDR, 1'b0);
        pulse(P_E2, 1'b0);
      end
      out[i] = tdo;
      pulse(P_SDR, w[i]);
    end
    pulse(P_E1, 1'b0);
    pulse(P_UDR, 1'b0);
  endtask

  logic [DR_W-1:0] got;

  initial begin
    clear_strobes();
    rst = 1'b1; tdi = 1'b0; ir_in = 1'b0; wr_ready = 1'b0; rd_data = '0;
    repeat (3) @(negedge tck);
    rst = 1'b0;
    check("reset_tdo", 64'(tdo), 64'd0);
    check("reset_wr_valid", 64'(wr_valid), 64'd0);
    check("reset_ir_out", 64'(ir_out), 64'd0);

    // Write commit with fabric ready.
    wr_ready = 1'b1;
    dr_scan(1'b1, 32'hDEADBEEF, 32, -1, got);
    check("wr_status_capture", 64'(got), 64'd0);
    check("wr_valid_after_udr", 64'(wr_valid), 64'd1);
    check("wr_data_deadbeef", 64'(wr_data), 64'hDEADBEEF);
    pulse(P_NONE, 1'b0);
    check("wr_valid_drops", 64'(wr_valid), 64'd0);

    // Read capture and ack.
    rd_data = 32'h12345678;
    dr_scan(1'b0, 32'h0, 32, -1, got);
    check("rd_tdo_stream", 64'(got), 64'h12345678);
    check("rd_ack_pulse", 64'(rd_ack), 64'd1);
    pulse(P_NONE, 1'b0);
    check("rd_ack_single", 64'(rd_ack), 64'd0);

    // Short scan flags len_err, visible in the next write capture, cleared by an IR scan.
    dr_scan(1'b1, 32'h5555AAAA, 31, -1, got);
    check("short_no_commit", 64'(wr_valid), 64'd0);
    dr_scan(1'b1, 32'h0, 32, -1, got);
    check("len_err_capture", 64'(got), 64'd1);
    pulse(P_CIR, 1'b0);
    pulse(P_UIR, 1'b0);
    dr_scan(1'b1, 32'h0, 32, -1, got);
    check("len_err_cleared", 64'(got), 64'd0);
    pulse(P_NONE, 1'b0);

    // Overrun while the fabric stalls.
    wr_ready = 1'b0;
    dr_scan(1'b1, 32'hA, 32, -1, got);
    dr_scan(1'b1, 32'hB, 32, -1, got);
    check("ovr_keeps_first", 64'(wr_data), 64'hA);
    pulse(P_CIR, 1'b0);
    check("ir_out_busy", 64'(ir_out), 64'd1);
    dr_scan(1'b1, 32'hC, 32, -1, got);
    check("ovr_status_capture", 64'(got), 64'd6);
    check("ovr_data_held", 64'(wr_data), 64'hA);
    wr_ready = 1'b1;
    pulse(P_NONE, 1'b0);
    check("stall_released", 64'(wr_valid), 64'd0);
    pulse(P_UIR, 1'b0);
    pulse(P_CIR, 1'b0);
    check("ir_out_idle", 64'(ir_out), 64'd0);

    // Pause-DR mid-scan.
    dr_scan(1'b1, 32'hCAFEF00D, 32, 16, got);
    check("pause_wr_data", 64'(wr_data), 64'hCAFEF00D);
    check("pause_wr_valid", 64'(wr_valid), 64'd1);
    pulse(P_NONE, 1'b0);

    // Illegal simultaneous strobes: capture wins.
    ir_in = 1'b0; rd_data = 32'h00000003;
    clear_strobes(); cdr = 1; sdr = 1; udr = 1; tdi = 1'b0;
    @(negedge tck);
    clear_strobes();
    check("priority_cdr", 64'(tdo), 64'd1);
    pulse(P_UDR, 1'b0);
    check("priority_no_ack", 64'(rd_ack), 64'd0);

    // Reset in the middle of a read scan.
    rd_data = 32'h0F0F0F0F;
    ir_in = 1'b0;
    pulse(P_CDR, 1'b0);
    for (int i = 0; i < 10; i++) pulse(P_SDR, 1'b0);
    rst = 1'b1;
    @(negedge tck);
    rst = 1'b0;
    check("rst_mid_tdo", 64'(tdo), 64'd0);
    check("rst_mid_wr_valid", 64'(wr_valid), 64'd0);
    pulse(P_UDR, 1'b0);
    check("rst_mid_no_ack", 64'(rd_ack), 64'd0);
    rd_data = 32'hA5A55A5A;
    dr_scan(1'b0, 32'h0, 32, -1, got);
    check("post_rst_read", 64'(got), 64'hA5A55A5A);
    check("post_rst_ack", 64'(rd_ack), 64'd1);
    repeat (2) @(negedge tck);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
